// File: rtl/if_stage_pkg.sv
// Shared CPU constants for the instruction-fetch stage: reset/trap vectors,
// the NOP encoding, the next-PC source encoding and the sequential PC increment.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Source of the next PC, listed lowest to highest priority
    typedef enum logic [2:0] {
        SEL_PC4,
        SEL_HOLD,
        SEL_BR,
        SEL_JUMP,
        SEL_JR,
        SEL_IRQ,
        SEL_EXC
    } pc_sel_e;

    // Sequential increment: the supervisor bit (31) is preserved and the
    // lower 31 bits wrap independently.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Combinational next-PC selection with fixed redirect priority:
// exc > irq > jr > jump > branch > stall > sequential.
module pc_next_sel
    import if_stage_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_irq,
    input  logic        i_exc,
    output logic [31:0] o_next_pc,
    output logic        o_redirect,
    output logic        o_irq_take,
    output logic        o_exc_take
);

    pc_sel_e w_sel;

    // Pick the winning PC source; irq is only honoured in user mode
    always_comb begin
        w_sel      = SEL_PC4;
        o_irq_take = 1'b0;
        o_exc_take = 1'b0;
        if (i_exc) begin
            w_sel      = SEL_EXC;
            o_exc_take = 1'b1;
        end else if (i_irq && !i_pc[31]) begin
            w_sel      = SEL_IRQ;
            o_irq_take = 1'b1;
        end else if (i_jr) begin
            w_sel = SEL_JR;
        end else if (i_jump) begin
            w_sel = SEL_JUMP;
        end else if (i_br_taken) begin
            w_sel = SEL_BR;
        end else if (i_stall) begin
            w_sel = SEL_HOLD;
        end
    end

    // Drive the next PC from the selected source; branch/jump cannot change mode
    always_comb begin
        o_next_pc  = pc_plus4(i_pc);
        o_redirect = 1'b1;
        case (w_sel)
            SEL_EXC:  o_next_pc = EXC_VEC;
            SEL_IRQ:  o_next_pc = IRQ_VEC;
            SEL_JR:   o_next_pc = i_jr_target;
            SEL_JUMP: o_next_pc = {i_pc[31], i_jump_target[30:0]};
            SEL_BR:   o_next_pc = {i_pc[31], i_br_target[30:0]};
            SEL_HOLD: begin
                o_next_pc  = i_pc;
                o_redirect = 1'b0;
            end
            default: begin
                o_next_pc  = pc_plus4(i_pc);
                o_redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the IF/ID pipeline register, the
// exception return address and the interrupt acknowledge pulse.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exc,
    output logic [31:0] instr_addr,
    input  logic [31:0] instruction,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] epc,
    output logic        irq_ack
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [31:0] r_epc;
    logic        r_irq_ack;

    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_irq_take;
    logic        w_exc_take;

    pc_next_sel #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_pc_next_sel (
        .i_pc          (r_pc),
        .i_stall       (stall),
        .i_br_taken    (br_taken),
        .i_br_target   (br_target),
        .i_jump        (jump),
        .i_jump_target (jump_target),
        .i_jr          (jr),
        .i_jr_target   (jr_target),
        .i_irq         (irq),
        .i_exc         (exc),
        .o_next_pc     (w_next_pc),
        .o_redirect    (w_redirect),
        .o_irq_take    (w_irq_take),
        .o_exc_take    (w_exc_take)
    );

    // PC register: stall hold is already folded into the selected next PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register: redirect inserts a bubble even under stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (w_redirect) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (!stall) begin
            r_ifid_instr <= instruction;
            r_ifid_pc4   <= pc_plus4(r_pc);
            r_ifid_valid <= 1'b1;
        end
    end

    // EPC: exc returns past the faulting instruction, irq re-executes the unfetched one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_epc <= 32'h0;
        end else if (w_exc_take) begin
            r_epc <= r_ifid_pc4;
        end else if (w_irq_take) begin
            r_epc <= r_pc;
        end
    end

    // Interrupt acknowledge: single-cycle pulse following the taken irq
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_ack <= 1'b0;
        end else begin
            r_irq_ack <= w_irq_take;
        end
    end

    assign instr_addr = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_valid = r_ifid_valid;
    assign epc        = r_epc;
    assign irq_ack    = r_irq_ack;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameters: RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 Parameters: IRQ_VEC, default 32'h8000_0004, the interrupt entry; EXC_VEC, default 32'h8000_0008, the exception entry.
REQ-003 The block SHALL have exactly these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID (load-use hazard from ID).
- br_taken  in  1  branch resolved taken.
- br_target  in  32  branch destination.
- jump  in  1  J/JAL in ID.
- jump_target  in  32  J/JAL destination.
- jr  in  1  JR/JALR in ID.
- jr_target  in  32  register destination.
- irq  in  1  level interrupt request.
- exc  in  1  undefined-instruction exception from ID.
- instr_addr  out  32  address to instruction memory, equal to the PC.
- instruction  in  32  combinational instruction memory data for instr_addr.
- ifid_instr  out  32  registered instruction.
- ifid_pc4  out  32  registered PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- epc  out  32  registered return address for $k0.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.

Function
REQ-004 instr_addr SHALL equal PC combinationally; instruction is sampled the same cycle (zero-latency ROM).
REQ-005 pc4 SHALL be {PC[31], PC[30:0]+4}; bit 31 (supervisor) never changes through sequential increment, and bits 30:0 wrap to 0 from 31'h7FFF_FFFC.
REQ-006 The next PC priority SHALL be, highest first: exc -> EXC_VEC; irq taken -> IRQ_VEC; jr -> jr_target; jump -> jump_target; br_taken -> br_target; stall -> PC held; else pc4.
REQ-007 An irq is taken only when irq=1, PC[31]=0 and exc=0; with PC[31]=1, irq is ignored with no latching.
REQ-008 jr_target SHALL load all 32 bits, so that jr can clear PC[31] (kernel return). Branch and jump targets SHALL have bit 31 forced to PC[31].
REQ-009 On exc or irq taken, epc SHALL load at the same edge: the PC for an irq (the unfetched instruction is re-executed) or ifid_pc4 for an exc. Otherwise epc holds.
REQ-010 irq_ack SHALL be 1 for exactly the cycle after an irq is taken. A level irq still high on return with PC[31]=0 is taken again.
REQ-011 Any redirect (exc, irq taken, jr, jump, br_taken) SHALL load IF/ID with a bubble: ifid_instr=0, ifid_valid=0, ifid_pc4=0. A redirect overrides stall.
REQ-012 With stall=1 and no redirect, PC, ifid_instr, ifid_pc4 and ifid_valid SHALL all hold.
REQ-013 Otherwise IF/ID SHALL load instruction, pc4 and valid=1.
REQ-014 If several redirect inputs are asserted at once, only the highest-priority one takes effect, with a single bubble.

Reset
REQ-015 While reset=0: PC=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, epc=0, irq_ack=0. This applies immediately, regardless of clk.
REQ-016 Deassertion mid-operation SHALL discard all in-flight state. The first fetch after release SHALL be at RESET_PC, on the first rising edge with reset=1.

Structure
REQ-017 RESET_PC, IRQ_VEC, EXC_VEC and the NOP encoding 32'h0000_0000 SHALL live in the shared CPU constants package.
REQ-018 Next-PC selection SHALL be one combinational sub-module, pc_next_sel. if_stage holds the PC, IF/ID, epc and irq_ack registers.
REQ-019 The implementation SHALL contain no latches and exactly one clocked always block per register group.

Verification
REQ-020 Reset low then released; instruction fixed at 32'h0800_0003 -> instr_addr=32'h8000_0000; after 1 edge ifid_instr=32'h0800_0003, ifid_pc4=32'h8000_0004, ifid_valid=1.
REQ-021 PC=32'h0000_0100, irq=1 -> next PC=32'h8000_0004, epc=32'h0000_0100, irq_ack pulses once, ifid_valid=0. Repeat with PC=32'h8000_0100 -> irq ignored, PC=32'h8000_0104.
REQ-022 stall=1 for 3 cycles at PC=32'h0000_0040 -> PC and IF/ID unchanged. Then stall=1 and br_taken=1 with br_target=32'h0000_0010 -> PC=32'h0000_0010, bubble.
REQ-023 exc=1, jr=1 and br_taken=1 in the same cycle, ifid_pc4=32'h0000_0024 -> PC=32'h8000_0008, epc=32'h0000_0024, a single bubble.
REQ-024 In kernel at PC=32'h8000_01C0, jr=1, jr_target=32'h0000_0100 -> PC=32'h0000_0100 (bit 31 cleared). jump_target=32'h0000_00BC from PC=32'h8000_0010 -> PC=32'h8000_00BC.
REQ-025 reset asserted between clock edges while PC=32'h0000_0200 -> PC=32'h8000_0000 and all outputs at reset values before the next edge.
